// File: rtl/wfft_frame_feeder.sv
// Circular sample store that replays overlapping analysis frames to the windowed FFT.
// A frame is WINDOW_POINTS consecutive reads from base; base advances by HOP per frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a full window of buffered samples and gap == 0
// EMIT  | issuing one read per cycle, k = 0..WINDOW_POINTS-1
module wfft_frame_feeder #(
  parameter int BIT_WIDTH     = 32,
  parameter int WINDOW_POINTS = 400,
  parameter int FFT_POINTS    = 512,
  parameter int HOP           = 160,
  parameter int BUF_DEPTH     = 1024
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 sample_valid,
  input  logic [BIT_WIDTH-1:0] sample_in,
  output logic                 start,
  output logic [BIT_WIDTH-1:0] sample_out,
  output logic                 frame_active,
  output logic                 overrun
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int KW = (WINDOW_POINTS > 1) ? $clog2(WINDOW_POINTS) : 1;
  localparam int GW = (FFT_POINTS > 2) ? $clog2(FFT_POINTS) : 1;

  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(BUF_DEPTH);
  localparam logic [AW:0]   WIN_V    = (AW+1)'(WINDOW_POINTS);
  localparam logic [AW:0]   HOP_V    = (AW+1)'(HOP);
  localparam logic [KW-1:0] K_LAST   = KW'(WINDOW_POINTS - 1);
  // Loading FFT_POINTS-1 on the first read and counting that same cycle leaves
  // FFT_POINTS-2 in the register, so gap hits 0 on first read + FFT_POINTS-1.
  localparam logic [GW-1:0] GAP_LOAD = GW'(FFT_POINTS - 2);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         base_q, base_d;
  logic [KW-1:0]       k_q, k_d;
  logic [GW-1:0]       gap_q, gap_d;
  logic                overrun_q, overrun_d;
  logic                start_q, start_d;
  logic                active_q, active_d;
  logic [BIT_WIDTH-1:0] rd_data_q;
  logic [BIT_WIDTH-1:0] mem [BUF_DEPTH];

  logic [AW:0]   avail;
  logic          wr_en;
  logic [AW-1:0] rd_addr;

  assign avail   = wr_ptr_q - base_q;
  assign wr_en   = sample_valid && (avail != DEPTH_V);
  assign rd_addr = base_q[AW-1:0] + AW'(k_q);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    base_d    = base_q;
    gap_d     = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    wr_ptr_d  = wr_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    overrun_d = overrun_q | (sample_valid & ~wr_en);
    start_d   = 1'b0;
    active_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((avail >= WIN_V) && (gap_q == '0)) state_d = EMIT;
      end
      EMIT: begin
        active_d = 1'b1;
        if (k_q == '0) begin
          start_d = 1'b1;
          gap_d   = GAP_LOAD;
        end
        if (k_q == K_LAST) begin
          k_d     = '0;
          base_d  = base_q + HOP_V;
          state_d = IDLE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      base_q    <= '0;
      k_q       <= '0;
      gap_q     <= '0;
      overrun_q <= 1'b0;
      start_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      base_q    <= base_d;
      k_q       <= k_d;
      gap_q     <= gap_d;
      overrun_q <= overrun_d;
      start_q   <= start_d;
      active_q  <= active_d;
    end
  end

  // Storage has no reset; its output is masked by frame_active instead.
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= sample_in;
    rd_data_q <= mem[rd_addr];
  end

  assign start        = start_q;
  assign frame_active = active_q;
  assign sample_out   = active_q ? rd_data_q : '0;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_wfft_frame_feeder.sv
// Directed-plus-random bench for wfft_frame_feeder, checked cycle by cycle against
// a sample-index model of frame scheduling, buffer occupancy and overrun.
module tb_wfft_frame_feeder;
  localparam int W   = 400;
  localparam int FFT = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sv_a, sv_b;
  logic [31:0] sin;
  logic        st_a, fa_a, ov_a, st_b, fa_b, ov_b;
  logic [31:0] so_a, so_b;

  wfft_frame_feeder dut (
    .clk_in(clk), .rst_in(rst_a), .sample_valid(sv_a), .sample_in(sin),
    .start(st_a), .sample_out(so_a), .frame_active(fa_a), .overrun(ov_a)
  );

  wfft_frame_feeder #(.BUF_DEPTH(512), .HOP(1)) dut_ov (
    .clk_in(clk), .rst_in(rst_b), .sample_valid(sv_b), .sample_in(sin),
    .start(st_b), .sample_out(so_b), .frame_active(fa_b), .overrun(ov_b)
  );

  int compared = 0;
  int mismatched = 0;

  int hop_m, depth_m, acc, base_m, st, fbase, gap_ok, cyc, prev_start;
  bit ovr_m, have_f, sel, chk_gap;
  logic [31:0] store[$];
  logic [10:0] av;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    store.delete();
    acc    = 0;
    base_m = 0;
    ovr_m  = 1'b0;
    have_f = 1'b0;
    gap_ok = 0;
  endtask

  task automatic check_outputs();
    logic        o_st, o_fa, o_ov;
    logic [31:0] o_so, e_so;
    bit          in_f;
    o_st = sel ? st_b : st_a;
    o_fa = sel ? fa_b : fa_a;
    o_ov = sel ? ov_b : ov_a;
    o_so = sel ? so_b : so_a;
    in_f = have_f && (cyc >= st) && (cyc <= st + W - 1);
    e_so = in_f ? store[fbase + cyc - st] : 32'd0;
    chk("start", 64'(o_st), 64'(have_f && cyc == st));
    chk("frame_active", 64'(o_fa), 64'(in_f));
    chk("sample_out", 64'(o_so), 64'(e_so));
    chk("overrun", 64'(o_ov), 64'(ovr_m));
    if (chk_gap && o_st) begin
      if (prev_start >= 0) chk("start_spacing", 64'(cyc - prev_start), 64'(FFT));
      prev_start = cyc;
    end
  endtask

  // One clock: decide/accept/advance in the model for the current cycle, then
  // clock the DUT and compare the outputs of the next cycle.
  task automatic step(input bit v, input logic [31:0] d);
    if ((!have_f || cyc >= st + W - 1) && cyc >= gap_ok && (acc - base_m) >= W) begin
      have_f = 1'b1;
      st     = cyc + 2;
      fbase  = base_m;
      gap_ok = st + FFT - 2;
    end
    if (v) begin
      if ((acc - base_m) < depth_m) begin
        store.push_back(d);
        acc++;
      end else begin
        ovr_m = 1'b1;
      end
    end
    if (have_f && cyc == st + W - 2) base_m += hop_m;
    sin  = d;
    sv_a = v && !sel;
    sv_b = v && sel;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset();
    if (sel) rst_b = 1'b0; else rst_a = 1'b0;
    sv_a = 1'b0;
    sv_b = 1'b0;
    #1;
    chk("rst_start", 64'(sel ? st_b : st_a), 64'(0));
    chk("rst_frame_active", 64'(sel ? fa_b : fa_a), 64'(0));
    chk("rst_sample_out", 64'(sel ? so_b : so_a), 64'(0));
    chk("rst_overrun", 64'(sel ? ov_b : ov_a), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    if (sel) rst_b = 1'b1; else rst_a = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; sv_a = 1'b0; sv_b = 1'b0; sin = '0;
    sel = 1'b0; hop_m = 160; depth_m = 1024; chk_gap = 1'b0; prev_start = -1;
    cyc = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Slow feed 1..720: frames carry 1..400, 161..560, 321..720.
    for (int i = 1; i <= 720; i++) begin
      step(1'b1, 32'(i));
      for (int j = 0; j < 3; j++) step(1'b0, 32'd0);
    end
    for (int i = 0; i < 1300; i++) step(1'b0, 32'd0);

    // Full-rate counting input; starts must be exactly FFT apart.
    do_reset();
    chk_gap = 1'b1;
    prev_start = -1;
    for (int i = 0; i < 3000; i++) step(1'b1, 32'(i + 1));
    chk_gap = 1'b0;

    // Reset on the 100th output cycle of the next frame.
    for (int t = 0; t < 3000 && !(have_f && cyc == st + 99); t++) step(1'b0, 32'd0);
    chk("reach_mid_frame", 64'(have_f && cyc == st + 99), 64'(1));
    chk("pre_reset_active", 64'(fa_a), 64'(1));
    do_reset();
    for (int i = 0; i < 399; i++) step(1'b1, $urandom());
    for (int i = 0; i < 40; i++) step(1'b0, 32'd0);
    step(1'b1, $urandom());
    for (int i = 0; i < 450; i++) step(1'b0, 32'd0);

    // Write on the exact last-read cycle of a frame.
    do_reset();
    for (int i = 0; i < 400; i++) step(1'b1, $urandom());
    for (int t = 0; t < 1000 && !(have_f && cyc == st + W - 2); t++) step(1'b0, 32'd0);
    chk("reach_last_read", 64'(have_f && cyc == st + W - 2), 64'(1));
    av = dut.wr_ptr_q - dut.base_q;
    chk("avail_before", 64'(av), 64'(acc - base_m));
    step(1'b1, 32'hC011_15E0);
    av = dut.wr_ptr_q - dut.base_q;
    chk("avail_after", 64'(av), 64'(acc - base_m));
    for (int i = 0; i < 159; i++) step(1'b1, $urandom());
    for (int i = 0; i < 1100; i++) step(1'b0, 32'd0);

    // Small buffer, HOP=1: overrun must rise on the first drop and stay.
    sel = 1'b1;
    hop_m = 1;
    depth_m = 512;
    do_reset();
    for (int i = 0; i < 2000; i++) step(1'b1, $urandom());
    chk("overrun_sticky", 64'(ov_b), 64'(ovr_m));
    for (int i = 0; i < 700; i++) step(1'b0, 32'd0);
    chk("overrun_held", 64'(ov_b), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
